jtpang_bank_resp: RTL and testbench

JTPANG_BANK_RESP -- requirements
Module: jtpang_bank_resp

---
 rtl/jtpang_bank_resp.sv | 159 +++++++++++++++
 tb/tb_jtpang_bank_resp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_bank_resp.sv
// jtpang_bank_resp: four-bank round-robin read responder in front of a
// fixed-latency memory. One transaction in flight. Each grant issues BURST
// consecutive word reads, and the words come back LATENCY cycles after each
// strobe.
// Optional feature: define JTPANG_BANK_RESP_STATS_EN to build the
// busy-cycle counter on dbg_busy_cnt. Without it the output is tied to 0.
//
// Handshake: the requester holds ba_rd[g] high until it sees ba_ack[g].
// The ack cycle is the grant cycle, and ba<g>_addr is sampled in that cycle.
// The ack, the first mem_rd and mem_addr are combinational in IDLE. This lets
// a waiting bank be granted on the first IDLE cycle after ba_rdy.
module jtpang_bank_resp #(
    parameter int LATENCY = 2,
    parameter int BURST   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [3:0]  ba_rd,
    output logic [3:0]  ba_ack,
    output logic [3:0]  ba_dst,
    output logic [3:0]  ba_dok,
    output logic [3:0]  ba_rdy,
    output logic [15:0] data_read,
    output logic [21:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_dout,
    output logic [15:0] dbg_busy_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t       r_state;
    logic [1:0]   r_ptr;        // first bank examined by the next arbitration
    logic [1:0]   r_bank;       // bank owning the transaction in flight
    logic [21:0]  r_addr;       // next word address to issue
    logic [2:0]   r_cnt;        // words issued so far
    logic [LATENCY:1] r_pv;     // read in flight, one stage per cycle of latency
    logic [LATENCY:1] r_pf;     // stage carries word 0
    logic [LATENCY:1] r_pl;     // stage carries word BURST-1
    logic [15:0]  r_hold;       // last word delivered

    logic [3:0]   w_rot;
    logic [1:0]   w_off;
    logic [1:0]   w_gnt;
    logic [21:0]  w_gnt_addr;
    logic         w_take;
    logic         w_issue_last;
    logic         w_first;
    logic         w_last;

    // Round-robin pick: rotate requests so r_ptr lands on bit 0, then find the lowest set bit
    always_comb begin
        w_rot = 4'({ba_rd, ba_rd} >> r_ptr);
        w_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_rot[i]) w_off = 2'(i);
        end
        w_gnt = r_ptr + w_off;
    end

    // Address of the bank being granted
    always_comb begin
        case (w_gnt)
            2'd0:    w_gnt_addr = ba0_addr;
            2'd1:    w_gnt_addr = ba1_addr;
            2'd2:    w_gnt_addr = ba2_addr;
            default: w_gnt_addr = ba3_addr;
        endcase
    end

    // Grant and issue decode. rst_n gates the IDLE grant so that reset forces the outputs low at once
    assign w_take       = rst_n && (r_state == IDLE) && (ba_rd != 4'd0);
    assign w_issue_last = (r_state == ISSUE) && (r_cnt == 3'(BURST - 1));
    assign w_first      = w_take;
    assign w_last       = (w_take && (BURST == 1)) || w_issue_last;

    assign mem_rd    = w_take || (r_state == ISSUE);
    assign mem_addr  = w_take ? w_gnt_addr : r_addr;
    assign ba_ack    = w_take ? (4'd1 << w_gnt) : 4'd0;
    assign ba_dok    = r_pv[LATENCY] ? (4'd1 << r_bank) : 4'd0;
    assign ba_dst    = (r_pv[LATENCY] && r_pf[LATENCY]) ? (4'd1 << r_bank) : 4'd0;
    assign ba_rdy    = (r_pv[LATENCY] && r_pl[LATENCY]) ? (4'd1 << r_bank) : 4'd0;
    assign data_read = r_pv[LATENCY] ? mem_dout : r_hold;

    // Transaction FSM: grant, issue BURST reads, then wait for the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_bank  <= 2'd0;
            r_addr  <= 22'd0;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_bank  <= w_gnt;
                        r_ptr   <= w_gnt + 2'd1;
                        r_addr  <= w_gnt_addr + 22'd1;
                        r_cnt   <= 3'd1;
                        r_state <= (BURST == 1) ? DATA : ISSUE;
                    end
                end
                ISSUE: begin
                    r_addr <= r_addr + 22'd1;
                    r_cnt  <= r_cnt + 3'd1;
                    if (w_issue_last) r_state <= DATA;
                end
                DATA: begin
                    if (r_pv[LATENCY] && r_pl[LATENCY]) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Latency pipeline. Reset clears it, so words still in the memory pipe are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pf <= '0;
            r_pl <= '0;
        end else begin
            r_pv[1] <= mem_rd;
            r_pf[1] <= w_first;
            r_pl[1] <= w_last;
            for (int j = 2; j <= LATENCY; j++) begin
                r_pv[j] <= r_pv[j-1];
                r_pf[j] <= r_pf[j-1];
                r_pl[j] <= r_pl[j-1];
            end
        end
    end

    // Keep the last delivered word so data_read holds between bursts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hold <= 16'd0;
        else if (r_pv[LATENCY]) r_hold <= mem_dout;
    end

`ifdef JTPANG_BANK_RESP_STATS_EN
    logic [15:0] r_busy;

    // Busy counter: the grant cycle and every non-IDLE cycle count, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= 16'd0;
        else if ((w_take || (r_state != IDLE)) && (r_busy != 16'hFFFF)) r_busy <= r_busy + 16'd1;
    end

    assign dbg_busy_cnt = r_busy;
`else
    assign dbg_busy_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_jtpang_bank_resp.sv
// Bench for jtpang_bank_resp (LATENCY=2, BURST=2). A behavioural memory
// returns the low 16 bits of each address LATENCY cycles after its strobe.
// Expected words and addresses are queued at each grant and retired as the
// DUT produces them.
module tb_jtpang_bank_resp;
    localparam int L = 2;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] ba_addr [4];
    logic [3:0]  ba_rd = 4'd0;
    logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0] data_read;
    logic [21:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_dout;
    logic [15:0] dbg_busy_cnt;

    always #5 clk = ~clk;

    jtpang_bank_resp #(.LATENCY(L), .BURST(B)) dut (
        .clk(clk), .rst_n(rst_n),
        .ba0_addr(ba_addr[0]), .ba1_addr(ba_addr[1]),
        .ba2_addr(ba_addr[2]), .ba3_addr(ba_addr[3]),
        .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok),
        .ba_rdy(ba_rdy), .data_read(data_read), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_dout(mem_dout), .dbg_busy_cnt(dbg_busy_cnt)
    );

    // Memory model: the data is the low half of the address issued L cycles earlier
    logic [21:0] m_a [1:L];
    always @(posedge clk) begin
        m_a[1] <= mem_addr;
        for (int j = 2; j <= L; j++) m_a[j] <= m_a[j-1];
    end
    assign mem_dout = m_a[L][15:0];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ack_cyc = 0;
    int          rd_idx = 0;
    int          dk_idx = 0;
    logic [19:0] exp_q[$];     // {bank, first, last, data}
    logic [21:0] addr_q[$];
    int          glog[$];
    int          gcyc[$];
    logic [1:0]  m_ptr = 2'd0;
    logic [15:0] last_data = 16'd0;
    logic [3:0]  keep = 4'd0;  // banks that keep ba_rd high past their ack
    bit          rerq0 = 1'b0; // bank 0 re-requests after each of its rdy pulses

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] rd, input logic [1:0] p);
        logic [1:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (rd[idx]) return int'(idx);
        end
        return -1;
    endfunction

    function automatic int one_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor for one cycle, sampled at the falling edge
    task automatic observe();
        int          eg;
        logic [21:0] a;
        logic [19:0] e;
        logic [3:0]  eb;
        check("onehot", {4'd0, $countones(ba_ack) <= 1, $countones(ba_dst) <= 1,
                         $countones(ba_dok) <= 1, $countones(ba_rdy) <= 1}, 32'hF);
        if (ba_ack != 4'd0) begin
            eg = rr_pick(ba_rd, m_ptr);
            check("grant", one_idx(ba_ack), eg);
            m_ptr = 2'(eg) + 2'd1;
            glog.push_back(eg);
            gcyc.push_back(cyc);
            ack_cyc = cyc;
            rd_idx = 0;
            dk_idx = 0;
            for (int k = 0; k < B; k++) begin
                a = ba_addr[2'(eg)] + 22'(k);
                addr_q.push_back(a);
                exp_q.push_back({2'(eg), k == 0, k == B - 1, a[15:0]});
            end
        end
        if (mem_rd) begin
            if (addr_q.size() == 0) check("rd_extra", 1, 0);
            else begin
                check("mem_addr", mem_addr, addr_q.pop_front());
                check("rd_when", cyc - ack_cyc, rd_idx);
                rd_idx++;
            end
        end
        if (ba_dok != 4'd0) begin
            if (exp_q.size() == 0) check("dok_extra", {28'd0, ba_dok}, 0);
            else begin
                e = exp_q.pop_front();
                eb = 4'd1 << e[19:18];
                check("dok", ba_dok, eb);
                check("dst", ba_dst, e[17] ? eb : 4'd0);
                check("rdy", ba_rdy, e[16] ? eb : 4'd0);
                check("data", data_read, e[15:0]);
                check("dok_when", cyc - ack_cyc, L + dk_idx);
                dk_idx++;
                last_data = e[15:0];
            end
        end else begin
            check("strobe_idle", {ba_dst, ba_rdy}, 8'd0);
            check("hold", data_read, last_data);
        end
    endtask

    // One clock: observe, then update requests just after the rising edge
    task automatic cycle();
        logic [3:0] nrd;
        @(negedge clk);
        cyc++;
        observe();
        nrd = ba_rd & ~(ba_ack & ~keep);
        if (rerq0 && ba_rdy[0]) nrd[0] = 1'b1;
        @(posedge clk);
        #1;
        ba_rd = nrd;
    endtask

    task automatic flush_model();
        exp_q.delete();
        addr_q.delete();
        glog.delete();
        gcyc.delete();
        m_ptr = 2'd0;
        last_data = 16'd0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strobes"}, {ba_ack, ba_dst, ba_dok, ba_rdy, 3'd0, mem_rd}, 0);
        check({tag, "_data"}, data_read, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_busy"}, dbg_busy_cnt, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ba_rd = 4'd0;
        keep = 4'd0;
        rerq0 = 1'b0;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((ba_rd != 4'd0 || exp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check("drain_timeout", 1, 0);
        cycle();
        cycle();
    endtask

    initial begin
        bit hit;
        int n;
        for (int i = 0; i < 4; i++) ba_addr[i] = 22'd0;

        // Single request from bank 0
        do_reset();
        ba_addr[0] = 22'h000100;
        ba_rd = 4'b0001;
        drain(40);
        check("single_grants", glog.size(), 1);
`ifdef JTPANG_BANK_RESP_STATS_EN
        check("busy_cnt", dbg_busy_cnt, 16'd4);
`else
        check("busy_cnt", dbg_busy_cnt, 16'd0);
`endif

        // All four banks at once
        do_reset();
        for (int i = 0; i < 4; i++) ba_addr[i] = 22'($urandom_range(0, 22'h3FFFFF));
        ba_rd = 4'b1111;
        drain(80);
        check("cont_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) check("cont_order", glog[i], i);
        for (int i = 1; i < gcyc.size(); i++) check("cont_gap", gcyc[i] - gcyc[i-1], L + B);

        // Bank 0 re-requests after each rdy while bank 2 holds its request
        do_reset();
        ba_addr[0] = 22'h001234;
        ba_addr[2] = 22'h2ABCDE;
        keep = 4'b0100;
        rerq0 = 1'b1;
        ba_rd = 4'b0101;
        n = 0;
        while (glog.size() < 4 && n < 80) begin
            cycle();
            n++;
        end
        if (n >= 80) check("fair_timeout", 1, 0);
        keep = 4'd0;
        rerq0 = 1'b0;
        ba_rd = 4'd0;
        drain(40);
        for (int i = 0; i < 4 && i < glog.size(); i++) check("fair_order", glog[i], (i % 2 == 0) ? 0 : 2);

        // Address wraps to zero
        do_reset();
        ba_addr[3] = 22'h3FFFFF;
        ba_rd = 4'b1000;
        drain(40);
        check("wrap_grant", glog.size() > 0 ? glog[0] : -1, 3);

        // Random request mixes, with the arbiter pointer carried across rounds
        do_reset();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) ba_addr[i] = 22'($urandom_range(0, 22'h3FFFFF));
            ba_rd = 4'($urandom_range(1, 15));
            drain(80);
        end

        // Reset during the first data word of a burst
        do_reset();
        ba_addr[3] = 22'h0ABC00;
        keep = 4'b1000;
        ba_rd = 4'b1000;
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            cyc++;
            observe();
            if (ba_dst != 4'd0) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!hit) check("dst_timeout", 1, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", {ba_ack, ba_dst, ba_dok, ba_rdy, 3'd0, mem_rd}, 0);
        check("midrst_data", data_read, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_busy", dbg_busy_cnt, 0);
        flush_model();
        keep = 4'd0;
        ba_rd = 4'b1001;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_ack_held", ba_ack, 0);
        rst_n = 1'b1;
        n = 0;
        while (glog.size() == 0 && n < 20) begin
            cycle();
            n++;
        end
        check("rst_next_grant", glog.size() > 0 ? glog[0] : -1, 0);
        drain(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
